// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stall requests, sequences branch flushes
// and in-flight fetch discard, and runs a stall watchdog. Optional perf counters via PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned WDOG_LIMIT = 1024,
  parameter int unsigned WDOG_W     = 11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        stallreq_if_in,
  input  logic        stallreq_id_in,
  input  logic        stallreq_mem_in,
  input  logic        branch_flag_in,
  input  logic        if_busy_in,
  input  logic        if_done_in,
  output logic [5:0]  stall,
  output logic        flush_out,
  output logic        if_discard_out,
  output logic        hang_out,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_DISCARD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              hang_q, hang_d;
  logic              stall_any;

  // Priority-merged stall vector; a frozen core holds every stage.
  always_comb begin
    stall = 6'b000000;
    if (!rdy_in)
      stall = 6'b111111;
    else if (stallreq_mem_in)
      stall = 6'b011111;
    else if (stallreq_id_in)
      stall = 6'b000111;
    else if (stallreq_if_in || (state_q == ST_DISCARD))
      stall = 6'b000011;
  end

  // A branch parked in EX behind a MEM stall flushes once, when EX advances.
  assign flush_out      = branch_flag_in & ~stall[3];
  assign stall_any      = |stall;
  assign if_discard_out = (state_q == ST_DISCARD);
  assign hang_out       = hang_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      case (state_q)
        ST_RUN:     if (flush_out && if_busy_in && !if_done_in) state_d = ST_DISCARD;
        ST_DISCARD: if (if_done_in) state_d = ST_RUN;
        default:    state_d = ST_RUN;
      endcase
    end
  end

  // Watchdog: saturating run-length of stalled ready cycles, sticky hang flag.
  always_comb begin
    wdog_d = wdog_q;
    hang_d = hang_q;
    if (rdy_in) begin
      if (stall_any)
        wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + WDOG_W'(1);
      else
        wdog_d = '0;
      if (wdog_d == WDOG_MAX) hang_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wdog_q <= '0;
      hang_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      hang_q <= hang_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      perf_stall_q <= 32'h0;
      perf_flush_q <= 32'h0;
    end else begin
      if (rdy_in && stall_any) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush_out)           perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cnt = 32'h0;
  assign perf_flush_cnt = 32'h0;
`endif

endmodule
